// File: rtl/id_alu_issue.sv
// id_alu_issue: MIPS decode stage plus the ID/EX register that feeds the ALU (aluctrl/d1/d2).
// Latency: 1 cycle from accept (if_valid & id_ready) to ex_valid.
// Backpressure: ex_* hold while ex_valid & !ex_ready; a load-use hazard inserts STALL_CYCLES bubbles.
// Option: define ID_OVF_CHECK_EN to add the registered ex_ovf_chk output (add/sub/addi trap on overflow).

module id_alu_issue #(
  parameter int unsigned STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  output logic        id_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [4:0]  ex_aluctrl,
  output logic [31:0] ex_d1,
  output logic [31:0] ex_d2,
  output logic [4:0]  ex_rd,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_illegal
`ifdef ID_OVF_CHECK_EN
  ,
  output logic        ex_ovf_chk
`endif
);

  // The stall counter counts the bubbles still owed after the first one.
  localparam logic [1:0] STALL_RELOAD = 2'(STALL_CYCLES - 1);

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_shamt;
  logic [15:0] w_imm;

  assign w_opcode = instr[31:26];
  assign w_rs     = instr[25:21];
  assign w_rt     = instr[20:16];
  assign w_shamt  = instr[10:6];
  assign w_funct  = instr[5:0];
  assign w_imm    = instr[15:0];

  logic [4:0]  w_aluctrl;
  logic [31:0] w_d1;
  logic [31:0] w_d2;
  logic [4:0]  w_rd;
  logic        w_regwrite;
  logic        w_memread;
  logic        w_memwrite;
  logic        w_illegal;
  logic        w_uses_rt;

  // Decode opcode/funct into ALU control, operand selection and control flags.
  always_comb begin
    w_aluctrl  = 5'b00000;
    w_d1       = rs_data;
    w_d2       = {{16{w_imm[15]}}, w_imm};
    w_rd       = w_rt;
    w_regwrite = 1'b1;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_illegal  = 1'b0;
    w_uses_rt  = 1'b0;
    case (w_opcode)
      6'h00: begin
        w_uses_rt = 1'b1;
        w_d2      = rt_data;
        w_rd      = instr[15:11];
        case (w_funct)
          6'h20, 6'h21: w_aluctrl = 5'b00010;
          6'h22, 6'h23: w_aluctrl = 5'b00110;
          6'h24:        w_aluctrl = 5'b00000;
          6'h25:        w_aluctrl = 5'b00001;
          6'h27:        w_aluctrl = 5'b01100;
          6'h00, 6'h02, 6'h03: begin
            // Shift amount lives in the instruction; the shifted value comes from rt.
            w_aluctrl = (w_funct == 6'h00) ? 5'b01101 :
                        (w_funct == 6'h02) ? 5'b01110 : 5'b01111;
            w_d1      = rt_data;
            w_d2      = {27'b0, w_shamt};
          end
          default: w_illegal = 1'b1;
        endcase
      end
      6'h08, 6'h09: w_aluctrl = 5'b00010;
      6'h0C: begin
        w_aluctrl = 5'b00000;
        w_d2      = {16'h0000, w_imm};
      end
      6'h0D: begin
        w_aluctrl = 5'b00001;
        w_d2      = {16'h0000, w_imm};
      end
      6'h0F: begin
        w_aluctrl = 5'b00111;
        w_d2      = {w_imm, 16'h0000};
      end
      6'h23: begin
        w_aluctrl = 5'b00010;
        w_memread = 1'b1;
      end
      6'h2B: begin
        w_aluctrl  = 5'b00010;
        w_memwrite = 1'b1;
        w_uses_rt  = 1'b1;
        w_rd       = 5'd0;
        w_regwrite = 1'b0;
      end
      6'h04: begin
        w_aluctrl  = 5'b00110;
        w_d2       = rt_data;
        w_uses_rt  = 1'b1;
        w_rd       = 5'd0;
        w_regwrite = 1'b0;
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_rd == 5'd0) begin
      w_regwrite = 1'b0;
    end
    // Illegal instructions still flow down so EX can raise the exception, but do nothing.
    if (w_illegal) begin
      w_aluctrl  = 5'b00000;
      w_d1       = 32'h0;
      w_d2       = 32'h0;
      w_rd       = 5'd0;
      w_regwrite = 1'b0;
      w_memread  = 1'b0;
      w_memwrite = 1'b0;
    end
  end

  logic        r_valid;
  logic [1:0]  r_cnt;
  logic [4:0]  r_aluctrl;
  logic [31:0] r_d1;
  logic [31:0] r_d2;
  logic [4:0]  r_rd;
  logic        r_regwrite;
  logic        r_memread;
  logic        r_memwrite;
  logic        r_illegal;

  logic w_adv;
  logic w_cnt_zero;
  logic w_hazard;
  logic w_load;

  assign w_adv      = !r_valid | ex_ready;
  assign w_cnt_zero = (r_cnt == 2'd0);
  assign w_hazard   = if_valid & r_valid & r_memread & (r_rd != 5'd0) &
                      ((w_rs == r_rd) | (w_uses_rt & (w_rt == r_rd)));
  assign id_ready   = w_adv & w_cnt_zero & !w_hazard & !flush;
  assign w_load     = if_valid & id_ready;

  // Valid bit and stall counter: flush wins, then owed bubbles, then a new hazard, then accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_cnt   <= 2'd0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_cnt   <= 2'd0;
    end else if (w_adv) begin
      if (!w_cnt_zero) begin
        r_valid <= 1'b0;
        r_cnt   <= r_cnt - 2'd1;
      end else if (w_hazard) begin
        r_valid <= 1'b0;
        r_cnt   <= STALL_RELOAD;
      end else begin
        r_valid <= if_valid;
      end
    end
  end

  // Payload only changes on a real transfer, so it holds while EX backpressures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aluctrl  <= 5'b00000;
      r_d1       <= 32'h0;
      r_d2       <= 32'h0;
      r_rd       <= 5'd0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (w_load) begin
      r_aluctrl  <= w_aluctrl;
      r_d1       <= w_d1;
      r_d2       <= w_d2;
      r_rd       <= w_rd;
      r_regwrite <= w_regwrite;
      r_memread  <= w_memread;
      r_memwrite <= w_memwrite;
      r_illegal  <= w_illegal;
    end
  end

  assign ex_valid    = r_valid;
  assign ex_aluctrl  = r_aluctrl;
  assign ex_d1       = r_d1;
  assign ex_d2       = r_d2;
  assign ex_rd       = r_rd;
  assign ex_regwrite = r_regwrite;
  assign ex_memread  = r_memread;
  assign ex_memwrite = r_memwrite;
  assign ex_illegal  = r_illegal;

`ifdef ID_OVF_CHECK_EN
  logic w_ovf;
  logic r_ovf;

  // Only the trapping forms (add, sub, addi) request an overflow check.
  assign w_ovf = !w_illegal & (((w_opcode == 6'h00) & ((w_funct == 6'h20) | (w_funct == 6'h22))) |
                               (w_opcode == 6'h08));

  // Overflow-check flag travels with the rest of the payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_load) begin
      r_ovf <= w_ovf;
    end
  end

  assign ex_ovf_chk = r_ovf;
`endif

endmodule

// File: tb/tb_id_alu_issue.sv
// tb_id_alu_issue: directed scenarios plus randomized traffic against a behavioural model.
// Latency: outputs sampled 1 time unit after the rising edge; id_ready sampled 1 unit after inputs.
// Backpressure: ex_ready is driven both directed and randomly.

module tb_id_alu_issue;

  localparam int STALL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic        flush = 1'b0;
  logic        ex_ready = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [31:0] rs_data = 32'h0;
  logic [31:0] rt_data = 32'h0;
  logic        id_ready;
  logic        ex_valid;
  logic [4:0]  ex_aluctrl;
  logic [31:0] ex_d1;
  logic [31:0] ex_d2;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_illegal;
`ifdef ID_OVF_CHECK_EN
  logic        ex_ovf_chk;
`endif

  id_alu_issue #(.STALL_CYCLES(STALL)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .id_ready(id_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_aluctrl(ex_aluctrl),
    .ex_d1(ex_d1), .ex_d2(ex_d2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_illegal(ex_illegal)
`ifdef ID_OVF_CHECK_EN
    , .ex_ovf_chk(ex_ovf_chk)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [4:0]  alu;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        ill;
    logic        ovf;
  } exp_t;

  logic [78:0] act;
  logic [9:0]  act_ctl;
  assign act     = {ex_valid, ex_aluctrl, ex_d1, ex_d2, ex_rd, ex_regwrite, ex_memread, ex_memwrite, ex_illegal};
  assign act_ctl = {ex_valid, ex_aluctrl, ex_regwrite, ex_memread, ex_memwrite, ex_illegal};

  function automatic logic [78:0] pack_out(input logic v, input exp_t e);
    return {v, e.alu, e.d1, e.d2, e.rd, e.rw, e.mr, e.mw, e.ill};
  endfunction

  function automatic logic [9:0] pack_ctl(input logic v, input exp_t e);
    return {v, e.alu, e.rw, e.mr, e.mw, e.ill};
  endfunction

  function automatic exp_t mk(input logic [4:0] alu, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [4:0] rd, input logic rw, input logic mr, input logic mw);
    exp_t e;
    e = '0;
    e.alu = alu; e.d1 = d1; e.d2 = d2; e.rd = rd; e.rw = rw; e.mr = mr; e.mw = mw;
    return e;
  endfunction

  // Reference decode written straight from the instruction tables.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [15:0] imm;
    bit bad;
    op = ins[31:26];
    fn = ins[5:0];
    imm = ins[15:0];
    e = '0;
    bad = 0;
    if (op == 6'h00) begin
      e.d1 = a; e.d2 = b; e.rd = ins[15:11]; e.rw = 1'b1;
      case (fn)
        6'h20: begin e.alu = 5'b00010; e.ovf = 1'b1; end
        6'h21: e.alu = 5'b00010;
        6'h22: begin e.alu = 5'b00110; e.ovf = 1'b1; end
        6'h23: e.alu = 5'b00110;
        6'h24: e.alu = 5'b00000;
        6'h25: e.alu = 5'b00001;
        6'h27: e.alu = 5'b01100;
        6'h00: begin e.alu = 5'b01101; e.d1 = b; e.d2 = {27'b0, ins[10:6]}; end
        6'h02: begin e.alu = 5'b01110; e.d1 = b; e.d2 = {27'b0, ins[10:6]}; end
        6'h03: begin e.alu = 5'b01111; e.d1 = b; e.d2 = {27'b0, ins[10:6]}; end
        default: bad = 1;
      endcase
    end else begin
      e.d1 = a; e.d2 = {{16{imm[15]}}, imm}; e.rd = ins[20:16]; e.rw = 1'b1;
      case (op)
        6'h08: begin e.alu = 5'b00010; e.ovf = 1'b1; end
        6'h09: e.alu = 5'b00010;
        6'h0C: begin e.alu = 5'b00000; e.d2 = {16'h0, imm}; end
        6'h0D: begin e.alu = 5'b00001; e.d2 = {16'h0, imm}; end
        6'h0F: begin e.alu = 5'b00111; e.d2 = {imm, 16'h0}; end
        6'h23: begin e.alu = 5'b00010; e.mr = 1'b1; end
        6'h2B: begin e.alu = 5'b00010; e.mw = 1'b1; e.rd = 5'd0; e.rw = 1'b0; end
        6'h04: begin e.alu = 5'b00110; e.d2 = b; e.rd = 5'd0; e.rw = 1'b0; end
        default: bad = 1;
      endcase
    end
    if (e.rd == 5'd0) e.rw = 1'b0;
    if (bad) begin
      e = '0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic bit reads_rt(input logic [31:0] ins);
    return (ins[31:26] == 6'h00) || (ins[31:26] == 6'h2B) || (ins[31:26] == 6'h04);
  endfunction

  // Small register numbers so that load-use collisions are frequent.
  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0]  functs [11];
    int k;
    functs = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02, 6'h03, 6'h3F};
    r = $urandom;
    r[25:21] = 5'($urandom_range(0, 3));
    r[20:16] = 5'($urandom_range(0, 3));
    r[15:11] = 5'($urandom_range(0, 3));
    k = $urandom_range(0, 19);
    case (k)
      0, 1, 2, 3, 4, 5, 6: begin r[31:26] = 6'h00; r[5:0] = functs[$urandom_range(0, 10)]; end
      7:  r[31:26] = 6'h08;
      8:  r[31:26] = 6'h09;
      9:  r[31:26] = 6'h0C;
      10: r[31:26] = 6'h0D;
      11: r[31:26] = 6'h0F;
      12, 13, 14, 15: r[31:26] = 6'h23;
      16, 17: r[31:26] = 6'h2B;
      18: r[31:26] = 6'h04;
      default: r[31:26] = 6'h3F;
    endcase
    return r;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic fl, input logic er);
    if_valid = v; instr = ins; rs_data = a; rt_data = b; flush = fl; ex_ready = er;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    n_cmp++;
    if (act !== 79'h0) begin n_err++; $display("FAIL reset_state: got %h want 0", act); end
    n_cmp++;
    if (id_ready !== 1'b1) begin n_err++; $display("FAIL reset_id_ready: got %b want 1", id_ready); end
    rst = 1'b0;
    drive(1'b1, 32'h00221820, 32'd5, 32'd7, 1'b0, 1'b1);
    tick();
    n_cmp++;
    if (ex_valid !== 1'b1) begin n_err++; $display("FAIL reset_pre_valid: got %b want 1", ex_valid); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (act !== 79'h0) begin n_err++; $display("FAIL reset_async_clear: got %h want 0", act); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_add();
    do_reset();
    drive(1'b1, 32'h00221820, 32'd5, 32'd7, 1'b0, 1'b1);
    #1;
    n_cmp++;
    if (id_ready !== 1'b1) begin n_err++; $display("FAIL add_ready: got %b want 1", id_ready); end
    tick();
    n_cmp++;
    if (act !== pack_out(1'b1, mk(5'b00010, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0)))
      begin n_err++; $display("FAIL add_issue: got %h want %h", act,
                              pack_out(1'b1, mk(5'b00010, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0))); end
  endtask

  task automatic test_lui_sra();
    do_reset();
    drive(1'b1, 32'h3C041234, 32'h11, 32'h22, 1'b0, 1'b1);
    tick();
    n_cmp++;
    if (act !== pack_out(1'b1, mk(5'b00111, 32'h11, 32'h12340000, 5'd4, 1'b1, 1'b0, 1'b0)))
      begin n_err++; $display("FAIL lui: got %h", act); end
    drive(1'b1, 32'h00062903, 32'h33, 32'hFFFF0044, 1'b0, 1'b1);
    tick();
    n_cmp++;
    if (act !== pack_out(1'b1, mk(5'b01111, 32'hFFFF0044, 32'd4, 5'd5, 1'b1, 1'b0, 1'b0)))
      begin n_err++; $display("FAIL sra: got %h", act); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, 32'h8C220010, 32'h100, 32'h55, 1'b0, 1'b1);
    tick();
    n_cmp++;
    if (act !== pack_out(1'b1, mk(5'b00010, 32'h100, 32'h10, 5'd2, 1'b1, 1'b1, 1'b0)))
      begin n_err++; $display("FAIL lw_issue: got %h", act); end
    drive(1'b1, 32'h00411820, 32'd9, 32'd4, 1'b0, 1'b1);
    for (int k = 0; k < STALL; k++) begin
      #1;
      n_cmp++;
      if (id_ready !== 1'b0) begin n_err++; $display("FAIL lu_ready_%0d: got %b want 0", k, id_ready); end
      tick();
      n_cmp++;
      if (ex_valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble_%0d: got %b want 0", k, ex_valid); end
    end
    #1;
    n_cmp++;
    if (id_ready !== 1'b1) begin n_err++; $display("FAIL lu_release: got %b want 1", id_ready); end
    tick();
    n_cmp++;
    if (act !== pack_out(1'b1, mk(5'b00010, 32'd9, 32'd4, 5'd3, 1'b1, 1'b0, 1'b0)))
      begin n_err++; $display("FAIL lu_add_issue: got %h", act); end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1'b1, 32'h00221820, 32'd5, 32'd7, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h342500FF, 32'hA0, 32'hB0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (id_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_%0d: got %b want 0", k, id_ready); end
      tick();
      n_cmp++;
      if (act !== pack_out(1'b1, mk(5'b00010, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0)))
        begin n_err++; $display("FAIL bp_hold_%0d: got %h", k, act); end
    end
    ex_ready = 1'b1;
    #1;
    n_cmp++;
    if (id_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got %b want 1", id_ready); end
    tick();
    n_cmp++;
    if (act !== pack_out(1'b1, mk(5'b00001, 32'hA0, 32'h000000FF, 5'd5, 1'b1, 1'b0, 1'b0)))
      begin n_err++; $display("FAIL bp_ori: got %h", act); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 32'h8C220010, 32'h100, 32'h55, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h00411820, 32'd9, 32'd4, 1'b1, 1'b1);
    #1;
    n_cmp++;
    if (id_ready !== 1'b0) begin n_err++; $display("FAIL fl_ready: got %b want 0", id_ready); end
    tick();
    n_cmp++;
    if (ex_valid !== 1'b0) begin n_err++; $display("FAIL fl_valid: got %b want 0", ex_valid); end
    flush = 1'b0;
    #1;
    n_cmp++;
    if (id_ready !== 1'b1) begin n_err++; $display("FAIL fl_cnt_cleared: got %b want 1", id_ready); end
    tick();
    n_cmp++;
    if (act !== pack_out(1'b1, mk(5'b00010, 32'd9, 32'd4, 5'd3, 1'b1, 1'b0, 1'b0)))
      begin n_err++; $display("FAIL fl_next_accept: got %h", act); end
    drive(1'b1, 32'h00221820, 32'd1, 32'd2, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (ex_valid !== 1'b0) begin n_err++; $display("FAIL fl_held_squash: got %b want 0", ex_valid); end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(1'b1, 32'h0022183F, 32'd5, 32'd7, 1'b0, 1'b1);
    tick();
    n_cmp++;
    if (act_ctl !== 10'b1_00000_0001) begin n_err++; $display("FAIL illegal_funct: got %b want 1000000001", act_ctl); end
    drive(1'b1, 32'hFC000000, 32'd5, 32'd7, 1'b0, 1'b1);
    tick();
    n_cmp++;
    if (act_ctl !== 10'b1_00000_0001) begin n_err++; $display("FAIL illegal_op: got %b want 1000000001", act_ctl); end
  endtask

`ifdef ID_OVF_CHECK_EN
  task automatic test_ovf();
    logic [31:0] ins [4];
    logic        want [4];
    ins  = '{32'h00221820, 32'h00221821, 32'h20220005, 32'h00221822};
    want = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    n_cmp++;
    if (ex_ovf_chk !== 1'b0) begin n_err++; $display("FAIL ovf_reset: got %b want 0", ex_ovf_chk); end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, ins[k], 32'd1, 32'd2, 1'b0, 1'b1);
      tick();
      n_cmp++;
      if (ex_ovf_chk !== want[k]) begin n_err++; $display("FAIL ovf_%0d: got %b want %b", k, ex_ovf_chk, want[k]); end
    end
  endtask
`endif

  task automatic test_random();
    bit   m_valid;
    int   m_stall;
    exp_t m_out;
    logic v, fl, er;
    logic [31:0] ins, a, b;
    bit adv, haz, rdy;
    do_reset();
    m_valid = 0;
    m_stall = 0;
    m_out = '0;
    for (int c = 0; c < 600; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      ins = rand_instr();
      a   = $urandom;
      b   = $urandom;
      fl  = ($urandom_range(0, 15) == 0);
      er  = ($urandom_range(0, 3) != 0);
      drive(v, ins, a, b, fl, er);
      #1;
      adv = !m_valid || er;
      haz = v && m_valid && m_out.mr && (m_out.rd != 5'd0) &&
            ((ins[25:21] == m_out.rd) || (reads_rt(ins) && ins[20:16] == m_out.rd));
      rdy = adv && (m_stall == 0) && !haz && !fl;
      n_cmp++;
      if (id_ready !== rdy) begin n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", c, id_ready, rdy); end
      if (fl) begin
        m_valid = 0;
        m_stall = 0;
      end else if (adv) begin
        if (m_stall > 0) begin
          m_valid = 0;
          m_stall--;
        end else if (haz) begin
          m_valid = 0;
          m_stall = STALL - 1;
        end else if (v) begin
          m_valid = 1;
          m_out = ref_decode(ins, a, b);
        end else begin
          m_valid = 0;
        end
      end
      tick();
      n_cmp++;
      if (!m_valid) begin
        if (ex_valid !== 1'b0) begin n_err++; $display("FAIL rnd_bubble c%0d: got %b want 0", c, ex_valid); end
      end else if (m_out.ill) begin
        if (act_ctl !== pack_ctl(1'b1, m_out)) begin
          n_err++; $display("FAIL rnd_illegal c%0d: got %b want %b", c, act_ctl, pack_ctl(1'b1, m_out));
        end
      end else begin
        if (act !== pack_out(1'b1, m_out)) begin
          n_err++; $display("FAIL rnd_payload c%0d: got %h want %h", c, act, pack_out(1'b1, m_out));
        end
      end
`ifdef ID_OVF_CHECK_EN
      if (m_valid) begin
        n_cmp++;
        if (ex_ovf_chk !== m_out.ovf) begin n_err++; $display("FAIL rnd_ovf c%0d: got %b want %b", c, ex_ovf_chk, m_out.ovf); end
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lui_sra();
    test_load_use();
    test_backpressure();
    test_flush();
    test_illegal();
`ifdef ID_OVF_CHECK_EN
    test_ovf();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
